// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Types and constants shared by the 8259A control-logic blocks.
//   level_t  : 3-bit interrupt level number (0..7)
//   mask_t   : 8-bit per-level mask (bit n = level n)
//   OCW2 command codes for data[7:5] = {R, SL, EOI}
//   num2bit  : binary level -> one-hot mask (1 << n)
//   bit2num  : one-hot mask -> index of lowest set bit; all-zero yields 7
// ---------------------------------------------------------------------------
package pic_pkg;

  typedef logic [2:0] level_t;
  typedef logic [7:0] mask_t;

  // OCW2 command field {R, SL, EOI}
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] NONSPEC_EOI  = 3'b001;
  localparam logic [2:0] SPEC_EOI     = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_NONSPEC  = 3'b101;
  localparam logic [2:0] SET_PRIO     = 3'b110;
  localparam logic [2:0] ROT_SPEC     = 3'b111;

  localparam level_t LOWEST_PRIORITY_RESET = 3'd7;

  function automatic mask_t num2bit(input level_t n);
    return mask_t'(8'h01 << n);
  endfunction

  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, so multi-hot inputs resolve to the lowest level.
  function automatic level_t bit2num(input mask_t m);
    level_t result;
    result = LOWEST_PRIORITY_RESET;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) result = level_t'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/pic_level_encoder.sv
// ---------------------------------------------------------------------------
// pic_level_encoder
// Combinational one-hot to binary level encoder. Returns the index of the
// lowest set bit; an all-zero input returns 3'd7.
//   one_hot : in  8  per-level mask
//   level   : out 3  encoded level
// ---------------------------------------------------------------------------
module pic_level_encoder
  import pic_pkg::*;
(
  input  logic [7:0] one_hot,
  output logic [2:0] level
);

  always_comb begin
    level = bit2num(one_hot);
  end

endmodule

// File: rtl/operation_control_word_2.sv
// ---------------------------------------------------------------------------
// operation_control_word_2
// OCW2 decode inside the 8259A control logic. Turns OCW2 writes (EOI,
// rotate and set-priority commands) and automatic-EOI acknowledge completion
// into the in-service clear mask, the rotate-on-AEOI flag and the current
// lowest-priority level consumed by the priority resolver.
//
// Ports
//   clock                          in  1  rising-edge clock
//   reset                          in  1  synchronous, active-high
//   write_initial_command_word_1   in  1  ICW1 strobe, re-initialises block
//   auto_eoi_config                in  1  AEOI mode bit from ICW4
//   end_of_acknowledge_sequence    in  1  pulse at end of INTA sequence
//   acknowledge_interrupt          in  8  one-hot level being acknowledged
//   write_operation_control_word_2 in  1  OCW2 strobe
//   internal_data_bus              in  8  [7]=R [6]=SL [5]=EOI [2:0]=L
//   highest_level_in_service       in  8  one-hot highest ISR bit
//   end_of_interrupt               out 8  ISR clear mask (combinational)
//   auto_rotate_mode               out 1  rotate-on-AEOI enabled (registered)
//   priority_rotate                out 3  lowest-priority level (registered)
//
// Build option
//   OCW2_SET_PRIORITY_EN : when defined, OCW2 code 3'b110 (set priority)
//                          loads priority_rotate from data[2:0]; otherwise
//                          that code is ignored.
// ---------------------------------------------------------------------------
module operation_control_word_2
  import pic_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       write_initial_command_word_1,
  input  logic       auto_eoi_config,
  input  logic       end_of_acknowledge_sequence,
  input  logic [7:0] acknowledge_interrupt,
  input  logic       write_operation_control_word_2,
  input  logic [7:0] internal_data_bus,
  input  logic [7:0] highest_level_in_service,
  output logic [7:0] end_of_interrupt,
  output logic       auto_rotate_mode,
  output logic [2:0] priority_rotate
);

  logic [2:0] command;
  level_t     command_level;
  level_t     in_service_level;
  level_t     acknowledge_level;

  assign command       = internal_data_bus[7:5];
  assign command_level = internal_data_bus[2:0];

  pic_level_encoder u_isr_encoder (
    .one_hot (highest_level_in_service),
    .level   (in_service_level)
  );

  pic_level_encoder u_ack_encoder (
    .one_hot (acknowledge_interrupt),
    .level   (acknowledge_level)
  );

  // -------------------------------------------------------------------------
  // ISR clear mask. Only the SL/EOI bits select the EOI flavour, so rotate
  // variants of an EOI clear exactly like their plain counterparts. AEOI
  // completion outranks a coincident OCW2 write.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no
    // latch is inferred.
    end_of_interrupt = '0;
    if (reset) begin
      end_of_interrupt = '0;
    end else if (write_initial_command_word_1) begin
      end_of_interrupt = 8'hFF;
    end else if (auto_eoi_config && end_of_acknowledge_sequence) begin
      end_of_interrupt = acknowledge_interrupt;
    end else if (write_operation_control_word_2) begin
      unique case (internal_data_bus[6:5])
        2'b01:   end_of_interrupt = highest_level_in_service;
        2'b11:   end_of_interrupt = num2bit(command_level);
        default: end_of_interrupt = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Rotate-on-AEOI flag.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous here, sampled only on the clock edge; state
    // updates use non-blocking assignments so every register sees the
    // pre-edge values of its neighbours.
    if (reset) begin
      auto_rotate_mode <= 1'b0;
    end else if (write_initial_command_word_1) begin
      auto_rotate_mode <= 1'b0;
    end else if (write_operation_control_word_2 && command == ROT_AEOI_SET) begin
      auto_rotate_mode <= 1'b1;
    end else if (write_operation_control_word_2 && command == ROT_AEOI_CLR) begin
      auto_rotate_mode <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Lowest-priority level. Rotating makes the just-serviced level the lowest
  // priority. OCW2 rotate commands outrank an automatic rotation in the same
  // cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      priority_rotate <= LOWEST_PRIORITY_RESET;
    end else if (write_initial_command_word_1) begin
      priority_rotate <= LOWEST_PRIORITY_RESET;
    end else if (write_operation_control_word_2 && command == ROT_NONSPEC) begin
      priority_rotate <= in_service_level;
    end else if (write_operation_control_word_2 && command == ROT_SPEC) begin
      priority_rotate <= command_level;
`ifdef OCW2_SET_PRIORITY_EN
    end else if (write_operation_control_word_2 && command == SET_PRIO) begin
      priority_rotate <= command_level;
`endif
    end else if (auto_rotate_mode && end_of_acknowledge_sequence) begin
      priority_rotate <= acknowledge_level;
    end
  end

endmodule

// File: tb/tb_operation_control_word_2.sv
// ---------------------------------------------------------------------------
// tb_operation_control_word_2
// Directed bench for the OCW2 decode block. Inputs change on the falling
// edge; end_of_interrupt is sampled 1 time unit later and the registered
// outputs 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_operation_control_word_2;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_initial_command_word_1;
  logic       auto_eoi_config;
  logic       end_of_acknowledge_sequence;
  logic [7:0] acknowledge_interrupt;
  logic       write_operation_control_word_2;
  logic [7:0] internal_data_bus;
  logic [7:0] highest_level_in_service;
  logic [7:0] end_of_interrupt;
  logic       auto_rotate_mode;
  logic [2:0] priority_rotate;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  operation_control_word_2 dut (
    .clock                          (clock),
    .reset                          (reset),
    .write_initial_command_word_1   (write_initial_command_word_1),
    .auto_eoi_config                (auto_eoi_config),
    .end_of_acknowledge_sequence    (end_of_acknowledge_sequence),
    .acknowledge_interrupt          (acknowledge_interrupt),
    .write_operation_control_word_2 (write_operation_control_word_2),
    .internal_data_bus              (internal_data_bus),
    .highest_level_in_service       (highest_level_in_service),
    .end_of_interrupt               (end_of_interrupt),
    .auto_rotate_mode               (auto_rotate_mode),
    .priority_rotate                (priority_rotate)
  );

  // Waits for the falling edge, then applies one full input vector.
  task automatic drive(input logic r, input logic icw1, input logic aeoi,
                       input logic eoas, input logic [7:0] ack,
                       input logic ocw2, input logic [7:0] data,
                       input logic [7:0] isr);
    @(negedge clock);
    reset                          = r;
    write_initial_command_word_1   = icw1;
    auto_eoi_config                = aeoi;
    end_of_acknowledge_sequence    = eoas;
    acknowledge_interrupt          = ack;
    write_operation_control_word_2 = ocw2;
    internal_data_bus              = data;
    highest_level_in_service       = isr;
    #1;
  endtask

  task automatic settle_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    // reset outranks a simultaneous ICW1 on the mask
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL reset_eoi: got %h want 00", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b0 || priority_rotate !== 3'd7) begin
      fails++;
      $display("FAIL reset_regs: arm=%b pr=%0d want 0/7", auto_rotate_mode, priority_rotate);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'hFF) begin
      fails++;
      $display("FAIL icw1_eoi: got %h want ff", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b0 || priority_rotate !== 3'd7) begin
      fails++;
      $display("FAIL icw1_regs: arm=%b pr=%0d want 0/7", auto_rotate_mode, priority_rotate);
    end
  endtask

  task automatic test_nonspec_eoi();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 8'h08);
    tests++;
    if (end_of_interrupt !== 8'h08) begin
      fails++;
      $display("FAIL nonspec_eoi: got %h want 08", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd7 || auto_rotate_mode !== 1'b0) begin
      fails++;
      $display("FAIL nonspec_hold: arm=%b pr=%0d want 0/7", auto_rotate_mode, priority_rotate);
    end
    // same ISR without the strobe gives no clear
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h08);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL no_strobe_eoi: got %h want 00", end_of_interrupt);
    end
  endtask

  task automatic test_spec_eoi();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h60, 8'h08);
    tests++;
    if (end_of_interrupt !== 8'h01) begin
      fails++;
      $display("FAIL spec_eoi_l0: got %h want 01", end_of_interrupt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h67, 8'h08);
    tests++;
    if (end_of_interrupt !== 8'h80) begin
      fails++;
      $display("FAIL spec_eoi_l7: got %h want 80", end_of_interrupt);
    end
    // SL=1, EOI=0 is not an EOI
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h43, 8'h08);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL noop_eoi: got %h want 00", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd7 || auto_rotate_mode !== 1'b0) begin
      fails++;
      $display("FAIL noop_hold: arm=%b pr=%0d want 0/7", auto_rotate_mode, priority_rotate);
    end
  endtask

  task automatic test_aeoi_priority();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 8'h60, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'h01) begin
      fails++;
      $display("FAIL aeoi_vs_ocw2_a: got %h want 01", end_of_interrupt);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 8'h60, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'h04) begin
      fails++;
      $display("FAIL aeoi_vs_ocw2_b: got %h want 04", end_of_interrupt);
    end
    // acknowledge end without AEOI configured clears nothing
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL no_aeoi_eoi: got %h want 00", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd7) begin
      fails++;
      $display("FAIL no_autorot: pr=%0d want 7", priority_rotate);
    end
  endtask

  task automatic test_rotate();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h10);
    tests++;
    if (end_of_interrupt !== 8'h10) begin
      fails++;
      $display("FAIL rot_nonspec_eoi: got %h want 10", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd4) begin
      fails++;
      $display("FAIL rot_nonspec_pr: pr=%0d want 4", priority_rotate);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hE3, 8'h10);
    tests++;
    if (end_of_interrupt !== 8'h08) begin
      fails++;
      $display("FAIL rot_spec_eoi: got %h want 08", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd3) begin
      fails++;
      $display("FAIL rot_spec_pr: pr=%0d want 3", priority_rotate);
    end
    // empty ISR encodes to 7; multi-hot ISR resolves to its lowest bit
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h00);
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd7) begin
      fails++;
      $display("FAIL rot_empty_isr: pr=%0d want 7", priority_rotate);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h44);
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd2) begin
      fails++;
      $display("FAIL rot_multihot: pr=%0d want 2", priority_rotate);
    end
  endtask

  task automatic test_auto_rotate();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL arm_set_eoi: got %h want 00", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b1 || priority_rotate !== 3'd2) begin
      fails++;
      $display("FAIL arm_set: arm=%b pr=%0d want 1/2", auto_rotate_mode, priority_rotate);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 8'h00);
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd5) begin
      fails++;
      $display("FAIL autorot_ack: pr=%0d want 5", priority_rotate);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h28, 1'b0, 8'h00, 8'h00);
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd3) begin
      fails++;
      $display("FAIL autorot_multihot: pr=%0d want 3", priority_rotate);
    end
    // OCW2 rotate beats automatic rotation in the same cycle
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'hE6, 8'h00);
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd6) begin
      fails++;
      $display("FAIL ocw2_beats_autorot: pr=%0d want 6", priority_rotate);
    end
    // code 010 changes nothing
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h45, 8'h00);
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b1 || priority_rotate !== 3'd6) begin
      fails++;
      $display("FAIL code010_hold: arm=%b pr=%0d want 1/6", auto_rotate_mode, priority_rotate);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b0) begin
      fails++;
      $display("FAIL arm_clr: arm=%b want 0", auto_rotate_mode);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00);
    settle_edge();
    tests++;
    if (priority_rotate !== 3'd6) begin
      fails++;
      $display("FAIL autorot_disabled: pr=%0d want 6", priority_rotate);
    end
  endtask

  task automatic test_set_priority();
    logic [2:0] expected;
`ifdef OCW2_SET_PRIORITY_EN
    expected = 3'd2;
`else
    expected = 3'd6;
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC2, 8'h10);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL set_prio_eoi: got %h want 00", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (priority_rotate !== expected) begin
      fails++;
      $display("FAIL set_prio_pr: pr=%0d want %0d", priority_rotate, expected);
    end
  endtask

  task automatic test_back_to_back();
    // arm auto-rotate, then ICW1 together with OCW2 must win
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'hE5, 8'h00);
    tests++;
    if (end_of_interrupt !== 8'hFF) begin
      fails++;
      $display("FAIL icw1_beats_all_eoi: got %h want ff", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b0 || priority_rotate !== 3'd7) begin
      fails++;
      $display("FAIL icw1_beats_all: arm=%b pr=%0d want 0/7", auto_rotate_mode, priority_rotate);
    end
    // build state, then reset in the middle of an OCW2 write
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hE5, 8'h00);
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b1 || priority_rotate !== 3'd5) begin
      fails++;
      $display("FAIL pre_reset_state: arm=%b pr=%0d want 1/5", auto_rotate_mode, priority_rotate);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'hA0, 8'h10);
    tests++;
    if (end_of_interrupt !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_eoi: got %h want 00", end_of_interrupt);
    end
    settle_edge();
    tests++;
    if (auto_rotate_mode !== 1'b0 || priority_rotate !== 3'd7) begin
      fails++;
      $display("FAIL mid_reset_regs: arm=%b pr=%0d want 0/7", auto_rotate_mode, priority_rotate);
    end
  endtask

  initial begin
    reset                          = 1'b1;
    write_initial_command_word_1   = 1'b0;
    auto_eoi_config                = 1'b0;
    end_of_acknowledge_sequence    = 1'b0;
    acknowledge_interrupt          = 8'h00;
    write_operation_control_word_2 = 1'b0;
    internal_data_bus              = 8'h00;
    highest_level_in_service       = 8'h00;

    test_reset();
    test_nonspec_eoi();
    test_spec_eoi();
    test_aeoi_priority();
    test_rotate();
    test_auto_rotate();
    test_set_priority();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operation_control_word_2.md
Name: operation_control_word_2

Overview:
- OCW2 decode block inside the 8259A control logic.
- Interprets OCW2 writes (EOI, rotate and set-priority commands) and automatic-EOI acknowledge completion.
- Drives the per-level EOI clear mask to the in-service register, the auto-rotate mode flag, and the lowest-priority level used by the priority resolver.

Parameters:
- None. Widths are fixed by the 8-level architecture.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- write_initial_command_word_1  in  1  ICW1 write strobe; re-initialises the block
- auto_eoi_config  in  1  AEOI mode bit latched from ICW4
- end_of_acknowledge_sequence  in  1  pulse at the end of the INTA sequence
- acknowledge_interrupt  in  8  one-hot level being acknowledged
- write_operation_control_word_2  in  1  OCW2 write strobe
- internal_data_bus  in  8  OCW2 byte: [7]=R, [6]=SL, [5]=EOI, [2:0]=level L
- highest_level_in_service  in  8  one-hot highest-priority ISR bit
- end_of_interrupt  out  8  ISR clear mask, one bit per level
- auto_rotate_mode  out  1  rotate-on-AEOI enabled
- priority_rotate  out  3  current lowest-priority level

Behaviour:
- Encodings:
  - one-hot→binary returns the index of the lowest set bit; all-zero input returns 3'd7.
  - binary→one-hot is 1<<n.
- end_of_interrupt is combinational, valid in the same cycle as its inputs. Evaluated in this priority order:
  1. reset=1 → 8'h00.
  2. write_initial_command_word_1=1 → 8'hFF (clears all ISR bits).
  3. auto_eoi_config & end_of_acknowledge_sequence → acknowledge_interrupt.
  4. write_operation_control_word_2=1, by data[6:5]: 2'b01 (non-specific) → highest_level_in_service; 2'b11 (specific) → one-hot(data[2:0]); otherwise → 8'h00.
  5. Otherwise → 8'h00.
- auto_rotate_mode is registered. On the clock edge, in priority order:
  - reset → 0.
  - ICW1 → 0.
  - OCW2 with data[7:5]=3'b100 → 1.
  - OCW2 with data[7:5]=3'b000 → 0.
  - Otherwise → hold.
- priority_rotate is registered. On the clock edge, in priority order:
  - reset → 3'd7.
  - ICW1 → 3'd7.
  - OCW2 with data[7:5]=3'b101 (rotate on non-specific EOI) → encode(highest_level_in_service).
  - OCW2 with data[7:5]=3'b111 (rotate on specific EOI) → data[2:0].
  - OCW2 with data[7:5]=3'b110 (set priority; only when the optional feature is enabled) → data[2:0].
  - auto_rotate_mode & end_of_acknowledge_sequence → encode(acknowledge_interrupt).
  - Otherwise → hold.
- Latency: one cycle for registered outputs, zero for end_of_interrupt.
- Simultaneous events:
  - ICW1 beats OCW2 and acknowledge completion.
  - OCW2 beats auto-rotate on acknowledge in the same cycle.
  - For end_of_interrupt, AEOI beats a simultaneous OCW2.
- Other data[7:5] codes (3'b001, 3'b011, 3'b010) leave both registers unchanged. 3'b010 is a no-op.
- Inputs are treated as already synchronised. Multi-hot one-hot inputs are resolved by lowest set bit.

Optional Feature:
- Macro OCW2_SET_PRIORITY_EN.
- Defined: OCW2 code 3'b110 loads priority_rotate from data[2:0]; end_of_interrupt is unaffected.
- Undefined: code 3'b110 is ignored and priority_rotate holds.

Decomposition:
- Shared package pic_pkg holds:
  - OCW2 command localparams (NONSPEC_EOI=3'b001, SPEC_EOI=3'b011, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000, ROT_NONSPEC=3'b101, ROT_SPEC=3'b111, SET_PRIO=3'b110).
  - Level typedef: 3-bit.
  - Mask typedef: 8-bit.
  - num2bit and bit2num functions.
- One natural sub-module, pic_level_encoder: 8-bit one-hot to 3-bit lowest-set-bit encoder, instantiated twice (ISR path and acknowledge path).

Test Plan:
- Reset, then pulse ICW1 → end_of_interrupt=8'hFF during the pulse; next edge auto_rotate_mode=0, priority_rotate=7.
- OCW2 data=8'h20, ISR=8'h08 → end_of_interrupt=8'h08; priority_rotate stays 7.
- OCW2 data=8'h60 → end_of_interrupt=8'h01.
- AEOI path: auto_eoi_config=1, end_of_acknowledge_sequence=1, acknowledge_interrupt=8'h01, OCW2 strobe also high with data=8'h60 → end_of_interrupt=8'h01 (AEOI priority).
- OCW2 data=8'hA0, ISR=8'h10 → end_of_interrupt=8'h10; next edge priority_rotate=4. Then OCW2 data=8'hE3 → end_of_interrupt=8'h08; priority_rotate=3.
- OCW2 data=8'h80 → auto_rotate_mode=1. Then end_of_acknowledge_sequence with acknowledge_interrupt=8'h20 → priority_rotate=5. Then OCW2 data=8'h00 → auto_rotate_mode=0. Assert reset mid-sequence → outputs return to 0 / 7.
